glove_region_detector: RTL
==========================

Name: glove_region_detector

Overview:
- Upstream stage of the shape/overlay renderer. Consumes the camera luma stream with its pixel coordinates and counts "glove" pixels (luma at or above a threshold) in each of four vertical screen strips over a frame.
- At end of frame it thresholds each count and debounces the result across frames.
- It drives the red/green/blue/yellow region flags that select the highlighted rectangle downstream.

Parameters:
- H_RES, 640, active horizontal pixels; strip width is H_RES/4.
- V_RES, 480, active lines; pixels with y_pos >= V_RES are ignored.
- LUMA_THRESH, 8'd200, a pixel is a hit when Y_in >= LUMA_THRESH.
- COUNT_THRESH, 17'd2000, a strip is hit for a frame when its count >= COUNT_THRESH.
- STABLE_FRAMES, 3, consecutive equal frame decisions required to change a flag (range 1..7).
- CNT_W, 17, width of the strip counters (covers 160*480 = 76800).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pixel_valid  in  1  Y_in/x_pos/y_pos valid this cycle.
- Y_in  in  8  pixel luma.
- x_pos  in  10  pixel column.
- y_pos  in  10  pixel row.
- frame_end  in  1  single-cycle pulse marking the last cycle of a frame.
- red_flag  out  1  strip 0 (x < 160) debounced glove present.
- green_flag  out  1  strip 1 (160..319).
- blue_flag  out  1  strip 2 (320..479).
- yellow_flag  out  1  strip 3 (480..639).
- flags_update  out  1  one-cycle pulse when flags are re-evaluated.

Behaviour:
- Reset (async, rst_n low):
  - All flags = 0 and flags_update = 0.
  - Counters, snapshots and streak counters = 0.
  - FSM = ACCUM.
- Strip index = x_pos / (H_RES/4) for x_pos < H_RES. Pixels with x_pos >= H_RES or y_pos >= V_RES are not counted.
- ACCUM:
  - When pixel_valid && in-range && Y_in >= LUMA_THRESH, increment that strip's counter.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- frame_end sampled high in ACCUM (cycle T):
  - The pixel presented in cycle T is included in the frame.
  - At the T edge all four counts, including that pixel, are copied to snapshot registers and the accumulators are cleared to 0.
  - FSM -> EVAL.
  - Pixels from T+1 onward count toward the next frame; accumulation never stops.
- EVAL (T+1):
  - hit[i] = (snapshot[i] >= COUNT_THRESH).
  - For each strip: on hit, hit_streak++ (saturating at STABLE_FRAMES) and miss_streak = 0; on miss, the reverse.
  - FSM -> UPDATE.
- UPDATE (T+2):
  - flag[i] <= 1 if hit_streak[i] == STABLE_FRAMES; flag[i] <= 0 if miss_streak[i] == STABLE_FRAMES; otherwise flag[i] holds.
  - flags_update = 1 for this cycle only.
  - FSM -> ACCUM.
- Latency: flags change on the T+2 edge. With STABLE_FRAMES = N, a persistent change appears at the end of the Nth consecutive frame.
- Strips are independent. Several flags may be 1 at once; priority resolution is done downstream.
- frame_end while in EVAL or UPDATE (frames shorter than 3 cycles):
  - The pulse is ignored and pixels keep accumulating into the current counters.
  - The next frame_end seen in ACCUM closes a frame containing both segments.
- frame_end held high for several cycles: each cycle seen in ACCUM is a new frame end. It is a protocol violation and is not protected against.
- Reset mid-frame: everything is cleared. The first frame after reset is partial and is evaluated normally.
- Outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 asynchronously mid-frame, with flags currently 1.
  - Response: all flags and flags_update go 0 immediately, with no clock edge needed.
- Single-strip detection:
  - Stimulus: three 640x480 frames, each with 3000 pixels of Y = 255 at x in 10..19 and all other pixels Y = 0.
  - Response: red_flag rises on the T+2 edge of the 3rd frame_end. The other flags stay 0. flags_update pulses 3 times.
- Threshold boundary:
  - Stimulus: strip 1 gets exactly 2000 hits per frame, then 1999 per frame; also vary luma between Y = 200 and Y = 199.
  - Response: 2000 counts as a hit and 1999 as a miss. Y = 200 counts and Y = 199 does not.
- Hysteresis:
  - Stimulus: with green_flag = 1, send frames in the pattern miss, miss, hit, miss, miss, miss.
  - Response: green_flag stays 1 through the hit-interrupted run and clears only after the 6th frame.
- Boundary and out-of-range pixels:
  - Stimulus: hits at x = 159, 160, 639, 640 and at y = 480; also a hit pixel presented in the frame_end cycle.
  - Response:
    - x = 159 goes to strip 0, x = 160 to strip 1, x = 639 to strip 3.
    - x = 640 and y = 480 are ignored.
    - The frame_end-cycle pixel is counted in the closing frame.
- Multi-strip and close frames:
  - Stimulus: strips 2 and 3 above threshold for 3 frames; then a second frame_end 2 cycles after the first.
  - Response: blue_flag and yellow_flag both set together. The early second pulse is ignored and its pixels carry into the next frame's counts.

Source files
------------

// File: rtl/glove_region_detector.sv
// Glove region detector: counts bright ("glove") pixels in four vertical
// screen strips per frame, thresholds each strip count at end of frame and
// debounces the per-strip decision across frames into the region flags.

// One strip: hit accumulator, end-of-frame snapshot, hit/miss streaks, flag.
module glove_strip #(
  parameter int              CNT_W         = 17,
  parameter logic [CNT_W-1:0] COUNT_THRESH = 17'd2000,
  parameter int              STABLE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit_px,   // qualified glove pixel in this strip this cycle
  input  logic snap_en,  // frame closes this cycle (pixel this cycle included)
  input  logic eval_en,  // compare snapshot, advance streaks
  input  logic upd_en,   // commit flag from streaks
  output logic flag
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0]       SF      = 3'(STABLE_FRAMES);

  logic [CNT_W-1:0] cnt, snap, cnt_nxt;
  logic [2:0]       hit_streak, miss_streak;

  // Saturating increment; this value is what the snapshot captures so the
  // frame_end-cycle pixel lands in the closing frame.
  assign cnt_nxt = (hit_px && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;

  // Accumulate hits; on frame close, snapshot the count and restart at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      snap <= '0;
    end else if (snap_en) begin
      snap <= cnt_nxt;
      cnt  <= '0;
    end else begin
      cnt  <= cnt_nxt;
    end
  end

  // Debounce: streaks saturate at SF, flag only moves on a full streak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_streak  <= '0;
      miss_streak <= '0;
      flag        <= 1'b0;
    end else begin
      if (eval_en) begin
        if (snap >= COUNT_THRESH) begin
          hit_streak  <= (hit_streak == SF) ? SF : hit_streak + 3'd1;
          miss_streak <= '0;
        end else begin
          miss_streak <= (miss_streak == SF) ? SF : miss_streak + 3'd1;
          hit_streak  <= '0;
        end
      end
      if (upd_en) begin
        if (hit_streak == SF)       flag <= 1'b1;
        else if (miss_streak == SF) flag <= 1'b0;
      end
    end
  end
endmodule

module glove_region_detector #(
  parameter int               H_RES         = 640,
  parameter int               V_RES         = 480,
  parameter logic [7:0]       LUMA_THRESH   = 8'd200,
  parameter int               CNT_W         = 17,
  parameter logic [CNT_W-1:0] COUNT_THRESH  = 17'd2000,
  parameter int               STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_valid,
  input  logic [7:0] Y_in,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       frame_end,
  output logic       red_flag,
  output logic       green_flag,
  output logic       blue_flag,
  output logic       yellow_flag,
  output logic       flags_update
);
  localparam int NUM_LANES = 4;
  localparam int STRIP_W   = H_RES / NUM_LANES;

  typedef enum logic [1:0] {ACCUM, EVAL, UPDATE} state_t;
  state_t state_q, state_d;

  logic                 pix_ok, snap_en, eval_en, upd_en;
  logic [NUM_LANES-1:0] strip_hit, flag;

  // Row in range and luma at/above threshold; column decides the strip.
  assign pix_ok = pixel_valid && ({1'b0, y_pos} < 11'(V_RES)) && (Y_in >= LUMA_THRESH);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next state and stage strobes; frame_end outside ACCUM is ignored so a
  // too-short frame merges into the following one.
  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    eval_en = 1'b0;
    upd_en  = 1'b0;
    case (state_q)
      ACCUM: begin
        if (frame_end) begin
          snap_en = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        eval_en = 1'b1;
        state_d = UPDATE;
      end
      UPDATE: begin
        upd_en  = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Strip decode and per-strip datapath; the last strip's upper bound is
  // H_RES, so columns at or past H_RES match no strip.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_strip
    localparam logic [10:0] LO = 11'(i * STRIP_W);
    localparam logic [10:0] HI = 11'((i + 1) * STRIP_W);

    assign strip_hit[i] = pix_ok && ({1'b0, x_pos} >= LO) && ({1'b0, x_pos} < HI);

    glove_strip #(
      .CNT_W         (CNT_W),
      .COUNT_THRESH  (COUNT_THRESH),
      .STABLE_FRAMES (STABLE_FRAMES)
    ) u_strip (
      .clk     (clk),
      .rst_n   (rst_n),
      .hit_px  (strip_hit[i]),
      .snap_en (snap_en),
      .eval_en (eval_en),
      .upd_en  (upd_en),
      .flag    (flag[i])
    );
  end

  // Update strobe is registered alongside the flags so both move on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_update <= 1'b0;
    else        flags_update <= upd_en;
  end

  assign red_flag    = flag[0];
  assign green_flag  = flag[1];
  assign blue_flag   = flag[2];
  assign yellow_flag = flag[3];
endmodule
